// File: rtl/thrdet_pkg.sv
// Shared constants and helpers for the channel threshold detector.
// THRDET_BIPOLAR_EN (optional) enables positive-crossing detection in the top level.
package thrdet_pkg;

  localparam int   TIMESTAMP_W = 32;
  localparam logic POL_NEG     = 1'b0;
  localparam logic POL_POS     = 1'b1;

  // Negation that cannot overflow: the most negative value maps to the most positive.
  function automatic logic signed [15:0] sat_neg(input logic signed [15:0] v);
    if (v == 16'sh8000) begin
      return 16'sh7fff;
    end
    return -v;
  endfunction

endpackage

// File: rtl/thrdet_chan_state.sv
// Per-channel detector state: {armed, armed_pos, refr_cnt} for each channel,
// one combinational read port and one write port, both addressed by channel number.
module thrdet_chan_state #(
  parameter int CHANNELS     = 8,
  parameter int CHANNELS_PW2 = 3,
  parameter int REFRACTORY_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CHANNELS_PW2-1:0] rd_idx,
  output logic                    rd_armed,
  output logic                    rd_armed_pos,
  output logic [REFRACTORY_W-1:0] rd_refr,
  input  logic                    wr_en,
  input  logic [CHANNELS_PW2-1:0] wr_idx,
  input  logic                    wr_armed,
  input  logic                    wr_armed_pos,
  input  logic [REFRACTORY_W-1:0] wr_refr
);

  logic                    armed_q     [CHANNELS];
  logic                    armed_d     [CHANNELS];
  logic                    armed_pos_q [CHANNELS];
  logic                    armed_pos_d [CHANNELS];
  logic [REFRACTORY_W-1:0] refr_q      [CHANNELS];
  logic [REFRACTORY_W-1:0] refr_d      [CHANNELS];
  logic [31:0]             rd_idx_ext;
  logic [31:0]             wr_idx_ext;

  // Indices beyond CHANNELS-1 read as all-zero and never write.
  always_comb begin
    rd_idx_ext   = 32'(rd_idx);
    wr_idx_ext   = 32'(wr_idx);
    rd_armed     = 1'b0;
    rd_armed_pos = 1'b0;
    rd_refr      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      armed_d[i]     = armed_q[i];
      armed_pos_d[i] = armed_pos_q[i];
      refr_d[i]      = refr_q[i];
      if (rd_idx_ext == 32'(i)) begin
        rd_armed     = armed_q[i];
        rd_armed_pos = armed_pos_q[i];
        rd_refr      = refr_q[i];
      end
      if (wr_en && (wr_idx_ext == 32'(i))) begin
        armed_d[i]     = wr_armed;
        armed_pos_d[i] = wr_armed_pos;
        refr_d[i]      = wr_refr;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (reset) begin
        armed_q[i]     <= 1'b0;
        armed_pos_q[i] <= 1'b0;
        refr_q[i]      <= '0;
      end else begin
        armed_q[i]     <= armed_d[i];
        armed_pos_q[i] <= armed_pos_d[i];
        refr_q[i]      <= refr_d[i];
      end
    end
  end

endmodule

// File: rtl/chan_threshold_detector.sv
// Threshold-crossing event detector on a time-multiplexed channel stream, with
// per-channel refractory suppression. Define THRDET_BIPOLAR_EN for positive crossings.
module chan_threshold_detector
  import thrdet_pkg::*;
#(
  parameter int CHANNELS     = 8,
  parameter int CHANNELS_PW2 = 3,
  parameter int REFRACTORY_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             chan_in_sample,
  input  logic [CHANNELS_PW2-1:0] chan_in_num,
  input  logic                    chan_in_valid,
  output logic                    chan_in_read,
  input  logic [15:0]             threshold,
  input  logic [REFRACTORY_W-1:0] refractory,
  output logic [CHANNELS_PW2-1:0] event_chan,
  output logic [TIMESTAMP_W-1:0]  event_time,
  output logic [15:0]             event_sample,
  output logic                    event_polarity,
  output logic                    event_valid,
  input  logic                    event_read
);

  // Handshake: a word transfers when chan_in_valid && chan_in_read; an event is
  // taken when event_valid && event_read. Input stalls only while an untaken event is held.

  logic                    st_armed, st_armed_pos;
  logic [REFRACTORY_W-1:0] st_refr;
  logic                    nx_armed, nx_armed_pos;
  logic [REFRACTORY_W-1:0] nx_refr;
  logic                    xfer, in_range, wr_en, refr_idle;
  logic                    neg_trig, pos_trig, trig;
  logic [31:0]             num_ext;
  logic signed [15:0]      smp, thr;
`ifdef THRDET_BIPOLAR_EN
  logic signed [15:0]      pos_lvl;
`endif

  logic                    event_valid_q, event_valid_d;
  logic [CHANNELS_PW2-1:0] event_chan_q, event_chan_d;
  logic [TIMESTAMP_W-1:0]  event_time_q, event_time_d;
  logic [15:0]             event_sample_q, event_sample_d;
  logic                    event_polarity_q, event_polarity_d;
  logic [TIMESTAMP_W-1:0]  frame_cnt_q, frame_cnt_d;

  thrdet_chan_state #(
    .CHANNELS     (CHANNELS),
    .CHANNELS_PW2 (CHANNELS_PW2),
    .REFRACTORY_W (REFRACTORY_W)
  ) u_state (
    .clk          (clk),
    .reset        (reset),
    .rd_idx       (chan_in_num),
    .rd_armed     (st_armed),
    .rd_armed_pos (st_armed_pos),
    .rd_refr      (st_refr),
    .wr_en        (wr_en),
    .wr_idx       (chan_in_num),
    .wr_armed     (nx_armed),
    .wr_armed_pos (nx_armed_pos),
    .wr_refr      (nx_refr)
  );

  always_comb begin
    chan_in_read = !event_valid_q || event_read;
    xfer         = chan_in_valid && chan_in_read;
    num_ext      = 32'(chan_in_num);
    in_range     = num_ext < 32'(CHANNELS);
    wr_en        = xfer && in_range;
    smp          = chan_in_sample;
    thr          = threshold;
    refr_idle    = (st_refr == '0);

    neg_trig = st_armed && refr_idle && (smp <= thr);
`ifdef THRDET_BIPOLAR_EN
    pos_lvl      = sat_neg(thr);
    pos_trig     = !neg_trig && st_armed_pos && refr_idle && (smp >= pos_lvl);
    nx_armed_pos = (smp < pos_lvl);
`else
    // Positive detection compiled out: armed_pos keeps its reset value.
    pos_trig     = 1'b0;
    nx_armed_pos = st_armed_pos;
`endif
    trig     = neg_trig || pos_trig;
    nx_armed = (smp > thr);

    if (trig) begin
      nx_refr = refractory;
    end else if (!refr_idle) begin
      nx_refr = st_refr - REFRACTORY_W'(1);
    end else begin
      nx_refr = st_refr;
    end

    event_valid_d    = event_valid_q;
    event_chan_d     = event_chan_q;
    event_time_d     = event_time_q;
    event_sample_d   = event_sample_q;
    event_polarity_d = event_polarity_q;
    // A new event replaces one being taken this cycle, so nothing is dropped.
    if (wr_en && trig) begin
      event_valid_d    = 1'b1;
      event_chan_d     = chan_in_num;
      event_time_d     = frame_cnt_q;
      event_sample_d   = chan_in_sample;
      event_polarity_d = neg_trig ? POL_NEG : POL_POS;
    end else if (event_read) begin
      event_valid_d    = 1'b0;
    end

    frame_cnt_d = frame_cnt_q;
    if (wr_en && (num_ext == 32'(CHANNELS - 1))) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      event_valid_q    <= 1'b0;
      event_chan_q     <= '0;
      event_time_q     <= '0;
      event_sample_q   <= '0;
      event_polarity_q <= 1'b0;
      frame_cnt_q      <= '0;
    end else begin
      event_valid_q    <= event_valid_d;
      event_chan_q     <= event_chan_d;
      event_time_q     <= event_time_d;
      event_sample_q   <= event_sample_d;
      event_polarity_q <= event_polarity_d;
      frame_cnt_q      <= frame_cnt_d;
    end
  end

  assign event_valid    = event_valid_q;
  assign event_chan     = event_chan_q;
  assign event_time     = event_time_q;
  assign event_sample   = event_sample_q;
  assign event_polarity = event_polarity_q;

endmodule

// File: tb/tb_chan_threshold_detector.sv
// Bench for chan_threshold_detector: directed tables, hand sequences and random
// traffic against an event-level reference model. Honours THRDET_BIPOLAR_EN.
module tb_chan_threshold_detector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] chan_in_sample = '0;
  logic [2:0]  chan_in_num = '0;
  logic        chan_in_valid = 1'b0;
  logic        chan_in_read;
  logic [15:0] threshold = 16'hff9c;
  logic [7:0]  refractory = '0;
  logic [2:0]  event_chan;
  logic [31:0] event_time;
  logic [15:0] event_sample;
  logic        event_polarity;
  logic        event_valid;
  logic        event_read = 1'b0;

  logic        c6_read;
  logic [2:0]  ev6_chan;
  logic [31:0] ev6_time;
  logic [15:0] ev6_sample;
  logic        ev6_pol;
  logic        ev6_valid;
  logic        ev6_read = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chan_threshold_detector #(.CHANNELS(8), .CHANNELS_PW2(3), .REFRACTORY_W(8)) dut (
    .clk(clk), .reset(reset), .chan_in_sample(chan_in_sample), .chan_in_num(chan_in_num),
    .chan_in_valid(chan_in_valid), .chan_in_read(chan_in_read), .threshold(threshold),
    .refractory(refractory), .event_chan(event_chan), .event_time(event_time),
    .event_sample(event_sample), .event_polarity(event_polarity), .event_valid(event_valid),
    .event_read(event_read)
  );

  chan_threshold_detector #(.CHANNELS(6), .CHANNELS_PW2(3), .REFRACTORY_W(8)) dut6 (
    .clk(clk), .reset(reset), .chan_in_sample(chan_in_sample), .chan_in_num(chan_in_num),
    .chan_in_valid(chan_in_valid), .chan_in_read(c6_read), .threshold(threshold),
    .refractory(refractory), .event_chan(ev6_chan), .event_time(ev6_time),
    .event_sample(ev6_sample), .event_polarity(ev6_pol), .event_valid(ev6_valid),
    .event_read(ev6_read)
  );

  // ---------------- reference model (event level) ----------------
  bit          m_armed [8];
`ifdef THRDET_BIPOLAR_EN
  bit          m_armedp [8];
`endif
  int          m_refr [8];
  logic [31:0] m_frame;
  logic        m_valid;
  logic [2:0]  m_chan;
  logic [31:0] m_time;
  logic [15:0] m_sample;
  logic        m_pol;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_armed[i] = 0;
`ifdef THRDET_BIPOLAR_EN
      m_armedp[i] = 0;
`endif
      m_refr[i] = 0;
    end
    m_frame = 0; m_valid = 0; m_chan = 0; m_time = 0; m_sample = 0; m_pol = 0;
  endtask

  task automatic model_step(input logic v, input logic [2:0] n, input logic [15:0] s,
                            input logic r);
    int ss, th;
    bit xfer, neg, pos;
    xfer = v && (!m_valid || r);
    neg = 0;
    pos = 0;
    if (xfer) begin
      ss  = int'($signed(s));
      th  = int'($signed(threshold));
      neg = m_armed[n] && (m_refr[n] == 0) && (ss <= th);
`ifdef THRDET_BIPOLAR_EN
      begin
        int plv;
        plv = (th == -32768) ? 32767 : -th;
        pos = !neg && m_armedp[n] && (m_refr[n] == 0) && (ss >= plv);
        m_armedp[n] = (ss < plv);
      end
`endif
      if (neg || pos) m_refr[n] = int'(refractory);
      else if (m_refr[n] > 0) m_refr[n] = m_refr[n] - 1;
      m_armed[n] = (ss > th);
      if (neg || pos) begin
        m_valid = 1; m_chan = n; m_time = m_frame; m_sample = s; m_pol = pos;
      end
      if (n == 3'd7) m_frame = m_frame + 1;
    end
    if (!(neg || pos) && r) m_valid = 0;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("model.event_valid", 32'(event_valid), 32'(m_valid));
    if (m_valid) begin
      chk("model.event_chan", 32'(event_chan), 32'(m_chan));
      chk("model.event_time", event_time, m_time);
      chk("model.event_sample", 32'(event_sample), 32'(m_sample));
      chk("model.event_polarity", 32'(event_polarity), 32'(m_pol));
    end
  endtask

  // One cycle: drive at the falling edge, check read, clock, check outputs.
  task automatic drive(input logic v, input logic [2:0] n, input logic [15:0] s,
                       input logic r);
    chan_in_valid  = v;
    chan_in_num    = n;
    chan_in_sample = s;
    event_read     = r;
    #1;
    chk("chan_in_read", 32'(chan_in_read), 32'(!m_valid || r));
    model_step(v, n, s, r);
    @(posedge clk);
    #1;
    compare_model();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    chan_in_valid = 1'b0;
    event_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    chk("reset.event_valid", 32'(event_valid), 0);
    chk("reset.event_chan", 32'(event_chan), 0);
    chk("reset.event_time", event_time, 0);
    chk("reset.event_sample", 32'(event_sample), 0);
    chk("reset.event_polarity", 32'(event_polarity), 0);
    chk("reset.chan_in_read", 32'(chan_in_read), 1);
    chk("reset.dut6_valid", 32'(ev6_valid), 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [15:0] thr;
    logic [7:0]  refr;
    logic [2:0]  n;
    logic [15:0] s;
    logic        e_valid;
    logic [2:0]  e_chan;
    logic [15:0] e_sample;
    logic        e_pol;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic [15:0] thr, input logic [7:0] refr, input logic [2:0] n,
                         input logic [15:0] s, input logic ev, input logic [2:0] ec,
                         input logic [15:0] es, input logic ep);
    vec_t t;
    t.thr = thr; t.refr = refr; t.n = n; t.s = s;
    t.e_valid = ev; t.e_chan = ec; t.e_sample = es; t.e_pol = ep;
    tbl.push_back(t);
  endtask

  logic bip;

  initial begin
`ifdef THRDET_BIPOLAR_EN
    bip = 1'b1;
`else
    bip = 1'b0;
`endif
    // threshold -100 = 16'hff9c, -150 = 16'hff6a, -99 = 16'hff9d, -32768 = 16'h8000
    add_vec(16'hff9c, 8'd0, 3'd3, 16'hff6a, 1'b0, 3'd0, 16'h0000, 1'b0);
    add_vec(16'hff9c, 8'd0, 3'd2, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0);
    add_vec(16'hff9c, 8'd0, 3'd2, 16'hff6a, 1'b1, 3'd2, 16'hff6a, 1'b0);
    add_vec(16'hff9c, 8'd0, 3'd2, 16'hff6a, 1'b0, 3'd0, 16'h0000, 1'b0);
    add_vec(16'hff9c, 8'd0, 3'd2, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0);
    add_vec(16'hff9c, 8'd0, 3'd2, 16'hff6a, 1'b1, 3'd2, 16'hff6a, 1'b0);
    add_vec(16'hff9c, 8'd0, 3'd2, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0);
    add_vec(16'hff9c, 8'd0, 3'd2, 16'hff9c, 1'b1, 3'd2, 16'hff9c, 1'b0);
    add_vec(16'hff9c, 8'd0, 3'd2, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0);
    add_vec(16'hff9c, 8'd0, 3'd2, 16'hff9d, 1'b0, 3'd0, 16'h0000, 1'b0);
    add_vec(16'hff9c, 8'd0, 3'd1, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0);
    add_vec(16'hff9c, 8'd0, 3'd1, 16'd150,  bip,  3'd1, 16'd150,  1'b1);
    add_vec(16'hff9c, 8'd0, 3'd1, 16'd100,  1'b0, 3'd0, 16'h0000, 1'b0);
    add_vec(16'hff9c, 8'd0, 3'd1, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0);
    add_vec(16'hff9c, 8'd0, 3'd1, 16'd100,  bip,  3'd1, 16'd100,  1'b1);
    add_vec(16'h8000, 8'd0, 3'd1, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0);
    add_vec(16'h8000, 8'd0, 3'd1, 16'h7ffe, 1'b0, 3'd0, 16'h0000, 1'b0);
    add_vec(16'h8000, 8'd0, 3'd1, 16'h7fff, bip,  3'd1, 16'h7fff, 1'b1);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      threshold  = tbl[i].thr;
      refractory = tbl[i].refr;
      drive(1'b1, tbl[i].n, tbl[i].s, 1'b1);
      chk($sformatf("tbl[%0d].valid", i), 32'(event_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl[%0d].chan", i), 32'(event_chan), 32'(tbl[i].e_chan));
        chk($sformatf("tbl[%0d].sample", i), 32'(event_sample), 32'(tbl[i].e_sample));
        chk($sformatf("tbl[%0d].pol", i), 32'(event_polarity), 32'(tbl[i].e_pol));
      end
    end

    // Refractory 3: channel 5 alternates 0 / -200 each frame; events every 4th frame.
    do_reset();
    threshold  = 16'hff9c;
    refractory = 8'd3;
    for (int f = 0; f < 12; f++) begin
      drive(1'b1, 3'd5, (f % 2 == 1) ? 16'hff38 : 16'h0000, 1'b1);
      chk($sformatf("refr.frame%0d.valid", f), 32'(event_valid), 32'((f % 4) == 1));
      if ((f % 4) == 1) chk($sformatf("refr.frame%0d.time", f), event_time, 32'(f));
      drive(1'b1, 3'd7, 16'h0000, 1'b1);
    end

    // Backpressure: a held event stalls input, then is replaced or cleared.
    do_reset();
    refractory = 8'd0;
    drive(1'b1, 3'd4, 16'h0000, 1'b1);
    drive(1'b1, 3'd6, 16'h0000, 1'b1);
    drive(1'b1, 3'd4, 16'hff6a, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd6, 16'hfed4, 1'b0);
      chk("stall.read", 32'(chan_in_read), 0);
      chk("stall.chan", 32'(event_chan), 4);
      chk("stall.sample", 32'(event_sample), 32'(16'hff6a));
    end
    drive(1'b1, 3'd6, 16'hfed4, 1'b1);
    chk("replace.valid", 32'(event_valid), 1);
    chk("replace.chan", 32'(event_chan), 6);
    chk("replace.sample", 32'(event_sample), 32'(16'hfed4));
    drive(1'b1, 3'd6, 16'h0000, 1'b1);
    chk("clear.valid", 32'(event_valid), 0);

    // Frame counter wrap: preload 0xFFFFFFFF, trigger before and after the wrap.
    do_reset();
    @(negedge clk);
    force dut.frame_cnt_d = 32'hffff_ffff;
    @(posedge clk);
    #1;
    release dut.frame_cnt_d;
    @(negedge clk);
    m_frame = 32'hffff_ffff;
    drive(1'b1, 3'd3, 16'h0000, 1'b1);
    drive(1'b1, 3'd3, 16'hff6a, 1'b1);
    chk("wrap.time_before", event_time, 32'hffff_ffff);
    drive(1'b1, 3'd7, 16'h0000, 1'b1);
    drive(1'b1, 3'd3, 16'h0000, 1'b1);
    drive(1'b1, 3'd3, 16'hff6a, 1'b1);
    chk("wrap.valid_after", 32'(event_valid), 1);
    chk("wrap.time_after", event_time, 0);

    // Out-of-range channel on a 6-channel instance: ignored entirely.
    do_reset();
    drive(1'b1, 3'd0, 16'h0000, 1'b1);
    drive(1'b1, 3'd7, 16'h0000, 1'b1);
    drive(1'b1, 3'd7, 16'h8ad0, 1'b1);
    chk("oor.no_event", 32'(ev6_valid), 0);
    drive(1'b1, 3'd6, 16'h8ad0, 1'b1);
    chk("oor.no_event6", 32'(ev6_valid), 0);
    drive(1'b1, 3'd0, 16'hff6a, 1'b1);
    chk("oor.in_range_event", 32'(ev6_valid), 1);
    chk("oor.chan", 32'(ev6_chan), 0);
    chk("oor.no_frame_inc", ev6_time, 0);

    // Random traffic against the model, with one mid-stream reset.
    do_reset();
    for (int it = 0; it < 2400; it++) begin
      logic [15:0] smp;
      if (it % 200 == 0) begin
        threshold  = 16'(-int'($urandom_range(2000, 20)));
        refractory = 8'($urandom_range(0, 4));
      end
      if (it == 1200) do_reset();
      if ($urandom_range(0, 3) == 0) smp = 16'($urandom);
      else smp = 16'(int'($urandom_range(0, 5000)) - 2500);
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), smp,
            $urandom_range(0, 9) < 7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
